// File: rtl/cpu_pkg.sv
// Shared types and defaults for the instruction fetch path.
package cpu_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
    } fetch_entry_t;

    // Word-align an address by clearing the byte-offset bits.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] a);
        return a & {{(WORD_W-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus: ROM address/data plus the decode handshake and control.
interface inst_fetch_ctrl_if;
    import cpu_pkg::*;

    logic [WORD_W-1:0] Addr;
    logic [WORD_W-1:0] Inst;
    logic              FetchValid;
    logic [WORD_W-1:0] FetchInst;
    logic [WORD_W-1:0] FetchPC;
    logic              FetchReady;
    logic              Redirect;
    logic [WORD_W-1:0] RedirectPC;
    logic              Halt;
    logic              Halted;

    modport master (
        output Addr, FetchValid, FetchInst, FetchPC, Halted,
        input  Inst, FetchReady, Redirect, RedirectPC, Halt
    );

    modport slave (
        input  Addr, FetchValid, FetchInst, FetchPC, Halted,
        output Inst, FetchReady, Redirect, RedirectPC, Halt
    );
endinterface

// File: rtl/fetch_buf.sv
// Show-ahead FIFO of {PC, Inst} entries; flush overrides push and pop.
module fetch_buf
    import cpu_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 push_data,
    output fetch_entry_t                 head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_en, push_en;

    always_comb begin
        pop_en   = pop && (count_q != '0);
        push_en  = push && ((count_q < CNT_W'(DEPTH)) || pop_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_en && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, feeds decode from a prefetch buffer.
module inst_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                DEPTH    = DEPTH_DEFAULT
) (
    input  logic              Clk,
    input  logic              Clrn,
    inst_fetch_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      head, push_entry;
    logic              fetch_valid, pop, push, flush;

    assign fetch_valid = (count != '0);
    assign pop         = fetch_valid && bus.FetchReady;
    assign push_entry  = '{pc: pc_q, inst: bus.Inst};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            BOOT:    state_d = bus.Halt ? HALT : RUN;
            RUN:     if (bus.Halt)  state_d = HALT;
            HALT:    if (!bus.Halt) state_d = RUN;
            default: state_d = BOOT;
        endcase
        // Redirect is ignored while booting; otherwise it beats any push or pop.
        if (bus.Redirect && state_q != BOOT) begin
            flush = 1'b1;
            pc_d  = align_word(bus.RedirectPC);
        end else if (state_q == RUN && !bus.Redirect
                     && ((count < CNT_W'(DEPTH)) || pop)) begin
            push = 1'b1;
            pc_d = pc_q + WORD_W'(4);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buf #(.DEPTH(DEPTH)) u_fetch_buf (
        .clk       (Clk),
        .rst_n     (Clrn),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .push_data (push_entry),
        .head_data (head),
        .count     (count)
    );

    assign bus.Addr       = pc_q;
    assign bus.FetchValid = fetch_valid;
    assign bus.FetchInst  = head.inst;
    assign bus.FetchPC    = head.pc;
    assign bus.Halted     = (state_q == HALT) && (count == '0);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Randomized and directed checks of inst_fetch_ctrl against a queue-based model.
module tb_inst_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

    logic Clk = 1'b0;
    logic Clrn;
    always #5 Clk = ~Clk;

    inst_fetch_ctrl_if bus ();

    logic [31:0] rom [32];
    assign bus.Inst = rom[bus.Addr[6:2]];

    inst_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .Clk  (Clk),
        .Clrn (Clrn),
        .bus  (bus)
    );

    // Reference model: an ordered list of fetched {pc, inst}, the PC and the mode.
    logic [63:0] m_q [$];
    logic [31:0] m_pc;
    int          m_mode;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic bit m_valid();
        return m_q.size() != 0;
    endfunction

    function automatic bit m_halted();
        return (m_mode == M_HALT) && (m_q.size() == 0);
    endfunction

    function automatic logic [63:0] m_head();
        return (m_q.size() != 0) ? m_q[0] : 64'd0;
    endfunction

    // Drive one clock of inputs and advance the model by the same edge.
    task automatic cycle(input bit rstn, input bit rdy, input bit redir,
                         input logic [31:0] rpc, input bit hlt);
        bit pop;
        Clrn = rstn; bus.FetchReady = rdy; bus.Redirect = redir;
        bus.RedirectPC = rpc; bus.Halt = hlt;
        @(posedge Clk);
        if (!rstn) begin
            m_q.delete();
            m_pc   = RESET_PC;
            m_mode = M_BOOT;
        end else begin
            pop = m_valid() && rdy;
            if (redir && m_mode != M_BOOT) begin
                m_q.delete();
                m_pc = rpc & 32'hFFFF_FFFC;
            end else begin
                if (pop) begin
                    $display("xfer pc=%h inst=%h", m_q[0][63:32], m_q[0][31:0]);
                    void'(m_q.pop_front());
                end
                if (m_mode == M_RUN && m_q.size() < DEPTH) begin
                    m_q.push_back({m_pc, rom[m_pc[6:2]]});
                    m_pc = m_pc + 32'd4;
                end
            end
            m_mode = hlt ? M_HALT : M_RUN;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        n_vec++;
        if (bus.FetchValid !== 1'b0 || bus.Halted !== 1'b0 || bus.Addr !== RESET_PC
            || bus.FetchInst !== 32'd0 || bus.FetchPC !== 32'd0) begin
            n_err++;
            $display("FAIL reset valid=%b halted=%b addr=%h pc=%h inst=%h required 0 0 %h 0 0",
                     bus.FetchValid, bus.Halted, bus.Addr, bus.FetchPC, bus.FetchInst, RESET_PC);
        end
    endtask

    task automatic test_stream();
        test_reset();
        for (int i = 1; i <= 10; i++) begin
            cycle(1, 1, 0, 0, 0);
            n_vec++;
            if (i == 1 ? (bus.FetchValid !== 1'b0)
                       : (bus.FetchValid !== 1'b1 || bus.FetchPC !== 32'(4 * (i - 2))
                          || bus.FetchInst !== rom[i - 2])) begin
                n_err++;
                $display("FAIL stream cyc=%0d valid=%b pc=%h inst=%h required pc=%h inst=%h",
                         i, bus.FetchValid, bus.FetchPC, bus.FetchInst, 32'(4 * (i - 2)),
                         (i >= 2) ? rom[i - 2] : 32'd0);
            end
        end
    endtask

    task automatic test_backpressure();
        test_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);
        n_vec++;
        if (bus.FetchValid !== 1'b1 || bus.FetchPC !== 32'h0 || bus.Addr !== 32'h8
            || {bus.FetchPC, bus.FetchInst} !== m_head()) begin
            n_err++;
            $display("FAIL backpressure_hold valid=%b pc=%h addr=%h required 1 00000000 00000008",
                     bus.FetchValid, bus.FetchPC, bus.Addr);
        end
        for (int k = 1; k <= 4; k++) begin
            cycle(1, 1, 0, 0, 0);
            n_vec++;
            if (bus.FetchValid !== 1'b1 || bus.FetchPC !== 32'(4 * k)
                || bus.FetchInst !== rom[k]) begin
                n_err++;
                $display("FAIL backpressure_release k=%0d pc=%h inst=%h required pc=%h inst=%h",
                         k, bus.FetchPC, bus.FetchInst, 32'(4 * k), rom[k]);
            end
        end
    endtask

    task automatic test_redirect();
        test_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 32'h0000_0039, 0);
        n_vec++;
        if (bus.FetchValid !== 1'b0 || bus.Addr !== 32'h38) begin
            n_err++;
            $display("FAIL redirect_flush valid=%b addr=%h required 0 00000038",
                     bus.FetchValid, bus.Addr);
        end
        cycle(1, 0, 0, 0, 0);
        n_vec++;
        if (bus.FetchValid !== 1'b1 || bus.FetchPC !== 32'h38 || bus.FetchInst !== rom[14]
            || bus.Addr !== 32'h3C) begin
            n_err++;
            $display("FAIL redirect_target valid=%b pc=%h inst=%h addr=%h required 1 00000038 %h 0000003c",
                     bus.FetchValid, bus.FetchPC, bus.FetchInst, bus.Addr, rom[14]);
        end
    endtask

    task automatic test_halt();
        test_reset();
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 1);
        n_vec++;
        if (bus.FetchValid !== 1'b1 || bus.FetchPC !== 32'h4 || bus.Halted !== 1'b0
            || bus.Addr !== 32'h8) begin
            n_err++;
            $display("FAIL halt_drain1 valid=%b pc=%h halted=%b addr=%h required 1 00000004 0 00000008",
                     bus.FetchValid, bus.FetchPC, bus.Halted, bus.Addr);
        end
        cycle(1, 1, 0, 0, 1);
        n_vec++;
        if (bus.FetchValid !== 1'b0 || bus.Halted !== 1'b1 || bus.Addr !== 32'h8) begin
            n_err++;
            $display("FAIL halt_empty valid=%b halted=%b addr=%h required 0 1 00000008",
                     bus.FetchValid, bus.Halted, bus.Addr);
        end
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        n_vec++;
        if (bus.FetchValid !== 1'b1 || bus.FetchPC !== 32'h8 || bus.FetchInst !== rom[2]
            || bus.Halted !== 1'b0) begin
            n_err++;
            $display("FAIL halt_resume valid=%b pc=%h inst=%h halted=%b required 1 00000008 %h 0",
                     bus.FetchValid, bus.FetchPC, bus.FetchInst, bus.Halted, rom[2]);
        end
    endtask

    task automatic test_wrap();
        test_reset();
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 1, 32'hFFFF_FFFC, 0);
        cycle(1, 1, 0, 0, 0);
        n_vec++;
        if (bus.FetchValid !== 1'b1 || bus.FetchPC !== 32'hFFFF_FFFC || bus.FetchInst !== rom[31]) begin
            n_err++;
            $display("FAIL wrap_top pc=%h inst=%h required fffffffc %h",
                     bus.FetchPC, bus.FetchInst, rom[31]);
        end
        cycle(1, 1, 0, 0, 0);
        n_vec++;
        if (bus.FetchValid !== 1'b1 || bus.FetchPC !== 32'h0 || bus.FetchInst !== rom[0]) begin
            n_err++;
            $display("FAIL wrap_zero pc=%h inst=%h required 00000000 %h",
                     bus.FetchPC, bus.FetchInst, rom[0]);
        end
    endtask

    task automatic test_midreset();
        test_reset();
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        n_vec++;
        if (bus.FetchValid !== 1'b0 || bus.Addr !== RESET_PC || bus.FetchPC !== 32'd0
            || bus.FetchInst !== 32'd0) begin
            n_err++;
            $display("FAIL midreset valid=%b addr=%h pc=%h inst=%h required 0 %h 0 0",
                     bus.FetchValid, bus.Addr, bus.FetchPC, bus.FetchInst, RESET_PC);
        end
        for (int i = 1; i <= 5; i++) begin
            cycle(1, 1, 0, 0, 0);
            n_vec++;
            if (i == 1 ? (bus.FetchValid !== 1'b0)
                       : (bus.FetchValid !== 1'b1 || bus.FetchPC !== 32'(4 * (i - 2))
                          || bus.FetchInst !== rom[i - 2])) begin
                n_err++;
                $display("FAIL midreset_restart cyc=%0d valid=%b pc=%h inst=%h required pc=%h",
                         i, bus.FetchValid, bus.FetchPC, bus.FetchInst, 32'(4 * (i - 2)));
            end
        end
    endtask

    task automatic test_random();
        bit hlt = 1'b0;
        test_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) hlt = ~hlt;
            cycle($urandom_range(0, 99) != 0, 1'($urandom), $urandom_range(0, 11) == 0,
                  $urandom, hlt);
            n_vec++;
            if (bus.FetchValid !== m_valid() || bus.Addr !== m_pc || bus.Halted !== m_halted()
                || (m_valid() && {bus.FetchPC, bus.FetchInst} !== m_head())) begin
                n_err++;
                $display("FAIL random cyc=%0d valid=%b/%b addr=%h/%h halted=%b/%b head=%h/%h",
                         i, bus.FetchValid, m_valid(), bus.Addr, m_pc, bus.Halted, m_halted(),
                         {bus.FetchPC, bus.FetchInst}, m_head());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        Clrn = 1'b0; bus.FetchReady = 1'b0; bus.Redirect = 1'b0;
        bus.RedirectPC = 32'd0; bus.Halt = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction fetch controller sitting between the core's decode stage and the combinational instruction ROM (32 words, word-indexed by `Addr[6:2]`). It owns the program counter, drives the ROM address, captures each returned word with its PC into a small prefetch buffer, and presents instructions to decode through a valid/ready handshake. Branch/jump targets are computed by the core and arrive as a redirect that flushes the buffer and reloads the PC.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `DEPTH`, 2, prefetch buffer entries (power of two, ≥2)
- `Clk`  in  1  sole clock, rising edge
- `Clrn`  in  1  reset, synchronous, active-low
- `Addr`  out  32  instruction ROM address (current PC)
- `Inst`  in  32  ROM read data, combinational from `Addr`
- `FetchValid`  out  1  buffer head holds a valid instruction
- `FetchInst`  out  32  instruction at buffer head
- `FetchPC`  out  32  PC of `FetchInst`
- `FetchReady`  in  1  decode accepts head this cycle
- `Redirect`  in  1  branch/jump taken; flush and reload PC
- `RedirectPC`  in  32  new PC; bits [1:0] ignored (forced to 0)
- `Halt`  in  1  stop issuing new fetches
- `Halted`  out  1  in HALT state and buffer empty

## Operation
- State machine, states BOOT, RUN, HALT.
  - BOOT: entered on reset; no push; next cycle → RUN (→ HALT if `Halt`=1).
  - RUN: push `{PC, Inst}` and PC ← PC+4 whenever push allowed; `Halt`=1 → HALT.
  - HALT: no push, PC frozen, buffer drains normally; `Halt`=0 → RUN.
- Push allowed when state is RUN, `Redirect`=0, and (count < DEPTH or a pop occurs the same cycle).
- Pop when `FetchValid` && `FetchReady`; head advances, count decrements.
- Redirect (any state except BOOT): buffer flushed (count ← 0), PC ← {RedirectPC[31:2],2'b00}, no push that cycle; a same-cycle pop is discarded (flush wins). State unchanged.
- `Addr` = PC at all times. PC arithmetic is 32-bit modular: 0xFFFF_FFFC + 4 → 0x0000_0000. ROM index wraps every 128 bytes by construction; controller does not mask.
- `Halted` = (state == HALT) && count == 0.
- `FetchInst`/`FetchPC` are don't-care when `FetchValid`=0 but must not change while `FetchValid`=1 and `FetchReady`=0 (stable-hold rule).

## Timing
- Reset (`Clrn`=0 at a rising edge): PC=RESET_PC, count=0, state=BOOT; outputs `FetchValid`=0, `Halted`=0, `Addr`=RESET_PC, `FetchInst`/`FetchPC`=0. Reset mid-operation discards buffer contents identically.
- First push: second rising edge after `Clrn` deasserts; `FetchValid`=1 one cycle after that push.
- Latency PC→FetchValid: 1 cycle (push edge). Redirect→first valid at new PC: 2 edges (reload, push).
- Throughput: one instruction per cycle sustained when `FetchReady` held 1.
- Full + pop same cycle: push proceeds, count unchanged.
- Empty + `FetchReady`=1: no pop, no underflow.
- `Redirect` and `Halt` same cycle: PC reloads, state → HALT, no push.

## Structure
- Shared package `cpu_pkg`: word width (32), `RESET_PC` default, fetch state enum {BOOT, RUN, HALT}.
- One sub-module `fetch_buf`: DEPTH-entry synchronous FIFO of 64-bit {PC, Inst} with push, pop, flush, count; flush priority over push/pop.

## Test plan
- Reset, `FetchReady`=1 constant → `FetchPC` sequence 0x00,0x04,0x08… one per cycle, `FetchInst` = ROM words 0,1,2.
- `FetchReady`=0 for 5 cycles after reset → count saturates at 2, PC stops at 0x08, head stays PC 0x00; release → 0x00,0x04,0x08 in order, no loss/duplication.
- `Redirect`=1, `RedirectPC`=0x0000_0039 while buffer full → buffer flushed, `FetchValid`=0 next cycle, then `FetchPC`=0x38 with ROM word 14.
- `Halt`=1 with 2 entries buffered → no new pushes, drains 2 instructions, `Halted`=1 when empty; `Halt`=0 → fetch resumes at the frozen PC.
- `RedirectPC`=0xFFFF_FFFC → fetches 0xFFFF_FFFC (ROM word 31) then 0x0000_0000 (word 0).
- `Clrn`=0 one cycle mid-stream with valid data → `FetchValid`=0, `Addr`=RESET_PC, restart matches first scenario.
